disp_chan_sel: RTL and testbench

DISP_CHAN_SEL -- requirements
Module: disp_chan_sel

---
 rtl/disp_pkg.sv | 14 +
 rtl/disp_scan_tick.sv | 43 ++++
 rtl/disp_chan_sel.sv | 133 +++++++++++++
 tb/tb_disp_chan_sel.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and source-select encoding for the display channel selector.
package disp_pkg;
    localparam int          CH_IDX_W         = 5;
    localparam logic [31:0] DISP_RST_PATTERN = 32'hAA5555AA;
    localparam logic [31:0] DISP_FILL        = 32'hFFFF_FFFF;
    localparam logic [4:0]  DISP_NONE_CH     = 5'd31;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_SCAN = 2'd1,
        SRC_CHAN = 2'd2,
        SRC_FILL = 2'd3
    } disp_src_e;
endpackage

// File: rtl/disp_scan_tick.sv
// Auto-scan divider and channel index; steps the index once every SCAN_DIV active cycles.
module disp_scan_tick
    import disp_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic                freeze,
    output logic [CH_IDX_W-1:0] scan_idx
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0]    div_r;
    logic [CH_IDX_W-1:0] idx_r;
    logic                tick_s;

    assign tick_s = (div_r == DIV_W'(SCAN_DIV - 1));

    // Divider and index; leaving scan mode clears both, freeze holds both.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
            idx_r <= {CH_IDX_W{1'b0}};
        end else if (!scan_en) begin
            div_r <= {DIV_W{1'b0}};
            idx_r <= {CH_IDX_W{1'b0}};
        end else if (freeze) begin
            div_r <= div_r;
            idx_r <= idx_r;
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
            idx_r <= (idx_r == CH_IDX_W'(NUM_CH - 1)) ? {CH_IDX_W{1'b0}} : idx_r + CH_IDX_W'(1);
        end else begin
            div_r <= div_r + DIV_W'(1);
            idx_r <= idx_r;
        end
    end

    assign scan_idx = idx_r;
endmodule

// File: rtl/disp_chan_sel.sv
// Seven-segment display source selector with channel-0 latch.
// Optional auto-scan across channels is built when DISP_AUTOSCAN_EN is defined.
module disp_chan_sel
    import disp_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DW       = 32,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN,
    input  logic [5:0]           ctrl,
    input  logic [NUM_CH*DW-1:0] ch_data,
    input  logic [DW-1:0]        reg_data,
    input  logic                 scan_en,
    input  logic                 freeze,
    output logic [DW-1:0]        seg7_data,
    output logic [CH_IDX_W-1:0]  cur_ch
);
    localparam logic [DW-1:0] RST_VAL  = DW'(DISP_RST_PATTERN);
    localparam logic [DW-1:0] FILL_VAL = {DW{DISP_FILL[0]}};

    if ((NUM_CH < 2) || (NUM_CH > 32) || (SCAN_DIV < 2)) begin : g_param_check
        $error("disp_chan_sel: NUM_CH must be 2..32 and SCAN_DIV >= 2");
    end

    logic [DW-1:0]       latch_r;
    logic [DW-1:0]       ch_arr_s [NUM_CH];
    logic [CH_IDX_W-1:0] sel_idx_s;
    logic [DW-1:0]       chan_val_s;
    logic [DW-1:0]       next_data_s;
    logic [CH_IDX_W-1:0] next_ch_s;
    disp_src_e           src_s;

`ifdef DISP_AUTOSCAN_EN
    logic [CH_IDX_W-1:0] scan_idx_s;

    disp_scan_tick #(
        .NUM_CH   (NUM_CH),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .scan_en  (scan_en),
        .freeze   (freeze),
        .scan_idx (scan_idx_s)
    );
`else
    logic scan_unused_s;
    assign scan_unused_s = scan_en;
`endif

    // Channel-0 latch follows EN regardless of freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_r <= RST_VAL;
        end else if (EN) begin
            latch_r <= ch_data[DW-1:0];
        end else begin
            latch_r <= latch_r;
        end
    end

    assign ch_arr_s[0] = latch_r;
    for (genvar c = 1; c < NUM_CH; c++) begin : g_ch
        assign ch_arr_s[c] = ch_data[c*DW +: DW];
    end

    // Source priority: register view, then scan, then manual channel, then fill.
    always_comb begin
        src_s     = SRC_FILL;
        sel_idx_s = ctrl[4:0];
        if (ctrl[5]) begin
            src_s = SRC_REG;
`ifdef DISP_AUTOSCAN_EN
        end else if (scan_en) begin
            src_s     = SRC_SCAN;
            sel_idx_s = scan_idx_s;
`endif
        end else if ({1'b0, ctrl[4:0]} < 6'(NUM_CH)) begin
            src_s = SRC_CHAN;
        end else begin
            src_s = SRC_FILL;
        end
    end

    // One-hot AND-OR channel mux; out-of-range indices never reach here as SRC_CHAN/SRC_SCAN.
    always_comb begin
        chan_val_s = {DW{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            chan_val_s = chan_val_s | (ch_arr_s[c] & {DW{sel_idx_s == CH_IDX_W'(c)}});
        end
    end

    // Next display value and channel tag from the chosen source.
    always_comb begin
        next_data_s = FILL_VAL;
        next_ch_s   = DISP_NONE_CH;
        case (src_s)
            SRC_REG: begin
                next_data_s = reg_data;
                next_ch_s   = DISP_NONE_CH;
            end
            SRC_SCAN, SRC_CHAN: begin
                next_data_s = chan_val_s;
                next_ch_s   = sel_idx_s;
            end
            SRC_FILL: begin
                next_data_s = FILL_VAL;
                next_ch_s   = DISP_NONE_CH;
            end
            default: begin
                next_data_s = FILL_VAL;
                next_ch_s   = DISP_NONE_CH;
            end
        endcase
    end

    // Registered display outputs, held while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg7_data <= RST_VAL;
            cur_ch    <= {CH_IDX_W{1'b0}};
        end else if (freeze) begin
            seg7_data <= seg7_data;
            cur_ch    <= cur_ch;
        end else begin
            seg7_data <= next_data_s;
            cur_ch    <= next_ch_s;
        end
    end
endmodule

// File: tb/tb_disp_chan_sel.sv
// Self-checking bench for disp_chan_sel: directed vector table, scan/freeze sequences,
// and randomized traffic against a reference model.
module tb_disp_chan_sel;
    localparam int NUM_CH   = 8;
    localparam int DW       = 32;
    localparam int SCAN_DIV = 4;

    logic                 clk = 1'b0;
    logic                 rst, EN, scan_en, freeze;
    logic [5:0]           ctrl;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [DW-1:0]        reg_data;
    logic [DW-1:0]        seg7_data;
    logic [4:0]           cur_ch;

    int total = 0;
    int bad   = 0;

    disp_chan_sel #(.NUM_CH(NUM_CH), .DW(DW), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .EN(EN), .ctrl(ctrl), .ch_data(ch_data),
        .reg_data(reg_data), .scan_en(scan_en), .freeze(freeze),
        .seg7_data(seg7_data), .cur_ch(cur_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic        frz;
        logic [5:0]  ctrl;
        logic [31:0] ch0;
        logic [31:0] rdat;
        logic [31:0] exp_seg;
        logic [4:0]  exp_cur;
    } vec_t;

    vec_t tbl [17];

    // Reference model state
    logic [31:0] m_latch;
    int          m_active;
    logic [31:0] m_seg;
    logic [4:0]  m_cur;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] es, input logic [4:0] ec);
        total++;
        if (seg7_data !== es || cur_ch !== ec) begin
            bad++;
            $display("FAIL %s: got seg7_data=%h cur_ch=%0d, want seg7_data=%h cur_ch=%0d",
                     nm, seg7_data, cur_ch, es, ec);
        end
    endtask

    function automatic logic [31:0] fixed_ch(input int c);
        return 32'(c) * 32'h1000_0001;
    endfunction

    function automatic logic [31:0] m_chan(input int c);
        if (c == 0) return m_latch;
        else return ch_data[c*32 +: 32];
    endfunction

    // Predict what the next clock edge does, from the inputs currently applied.
    task automatic model_step();
        logic [31:0] v;
        logic [4:0]  ch;
        bit          scanning;
        if (rst) begin
            m_latch  = 32'hAA5555AA;
            m_active = 0;
            m_seg    = 32'hAA5555AA;
            m_cur    = 5'd0;
        end else begin
`ifdef DISP_AUTOSCAN_EN
            scanning = (scan_en == 1'b1);
`else
            scanning = 1'b0;
`endif
            if (ctrl[5]) begin
                v = reg_data; ch = 5'd31;
            end else if (scanning) begin
                ch = 5'((m_active / SCAN_DIV) % NUM_CH);
                v  = m_chan(int'(ch));
            end else if (int'(ctrl[4:0]) < NUM_CH) begin
                ch = ctrl[4:0];
                v  = m_chan(int'(ch));
            end else begin
                v = 32'hFFFF_FFFF; ch = 5'd31;
            end
            if (!freeze) begin
                m_seg = v; m_cur = ch;
            end
            if (EN) m_latch = ch_data[31:0];
            if (!scanning) m_active = 0;
            else if (!freeze) m_active++;
        end
    endtask

    initial begin
        int          k;
        int          idx;
        logic [31:0] hold_seg;
        logic [4:0]  hold_cur;

        rst = 1'b0; EN = 1'b0; scan_en = 1'b0; freeze = 1'b0;
        ctrl = 6'd0; reg_data = 32'd0; ch_data = '0;
        for (int c = 1; c < NUM_CH; c++) ch_data[c*32 +: 32] = fixed_ch(c);

        //           rst   en    frz   ctrl        ch0           rdat          exp_seg       cur
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'd0,       32'h0,        32'h0,        32'hAA5555AA, 5'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'd0,       32'h12345678, 32'h0,        32'hAA5555AA, 5'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 6'd0,       32'h12345678, 32'h0,        32'hAA5555AA, 5'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'd0,       32'h0,        32'h0,        32'h12345678, 5'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'd0,       32'h0,        32'h0,        32'h12345678, 5'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'd5,       32'h0,        32'h0,        32'h50000005, 5'd5};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'b001010,  32'h0,        32'h0,        32'hFFFFFFFF, 5'd31};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 6'b100011,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 5'd31};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'd3,       32'h0,        32'h0,        32'h30000003, 5'd3};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'd7,       32'h0,        32'h0,        32'h70000007, 5'd7};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 6'd8,       32'h0,        32'h0,        32'hFFFFFFFF, 5'd31};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 6'd1,       32'h0,        32'h0,        32'hFFFFFFFF, 5'd31};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 6'd0,       32'hCAFEF00D, 32'h0,        32'hFFFFFFFF, 5'd31};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 6'd0,       32'h0,        32'h0,        32'hCAFEF00D, 5'd0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 6'd5,       32'h11111111, 32'h0,        32'hAA5555AA, 5'd0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 6'd0,       32'h0,        32'h0,        32'hAA5555AA, 5'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 6'b111111,  32'h0,        32'h13579BDF, 32'h13579BDF, 5'd31};

        #1;
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; EN = tbl[i].en; freeze = tbl[i].frz;
            ctrl = tbl[i].ctrl; ch_data[31:0] = tbl[i].ch0; reg_data = tbl[i].rdat;
            scan_en = 1'b0;
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp_seg, tbl[i].exp_cur);
        end

`ifdef DISP_AUTOSCAN_EN
        // Scan across all channels, with a reset in the middle restarting from channel 0.
        rst = 1'b0; EN = 1'b0; freeze = 1'b0; ctrl = 6'd0; ch_data[31:0] = 32'h0;
        scan_en = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            rst = (i == 11);
            tick();
            if (i == 11) begin
                k = 0;
                check($sformatf("scan_rst%0d", i), 32'hAA5555AA, 5'd0);
            end else begin
                k++;
                idx = ((k - 1) / SCAN_DIV) % NUM_CH;
                check($sformatf("scan%0d", i), (idx == 0) ? 32'hAA5555AA : fixed_ch(idx), 5'(idx));
            end
        end
        rst = 1'b0;

        // Freeze in mid-scan: outputs hold, scan position does not advance.
        for (int i = 0; i < 20; i++) begin
            freeze = (i >= 6 && i < 12);
            tick();
            if (freeze) begin
                check($sformatf("frz%0d", i), hold_seg, hold_cur);
            end else begin
                k++;
                idx = ((k - 1) / SCAN_DIV) % NUM_CH;
                hold_seg = (idx == 0) ? 32'hAA5555AA : fixed_ch(idx);
                hold_cur = 5'(idx);
                check($sformatf("frz_scan%0d", i), hold_seg, hold_cur);
            end
        end
        freeze = 1'b0;

        // Register view overrides the source while the scan keeps counting underneath.
        ctrl = 6'b100000; reg_data = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            tick();
            k++;
            check($sformatf("regov%0d", i), 32'h0BADF00D, 5'd31);
        end
        ctrl = 6'd0;
        tick();
        k++;
        idx = ((k - 1) / SCAN_DIV) % NUM_CH;
        check("regov_resume", (idx == 0) ? 32'hAA5555AA : fixed_ch(idx), 5'(idx));
        scan_en = 1'b0;
`else
        // Without auto-scan, scan_en has no effect on selection.
        rst = 1'b0; EN = 1'b0; freeze = 1'b0; scan_en = 1'b1; ctrl = 6'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("noscan%0d", i), 32'h30000003, 5'd3);
        end
        scan_en = 1'b0;
`endif

        // Randomized traffic against the reference model.
        m_latch = 32'h0; m_active = 0; m_seg = 32'h0; m_cur = 5'd0;
        for (int i = 0; i < 400; i++) begin
            rst    = (i == 0) || ($urandom_range(0, 49) == 0);
            EN     = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) scan_en = ~scan_en;
            if ($urandom_range(0, 3) == 0) ctrl = 6'($urandom_range(0, 63));
            else ctrl = {3'b000, 3'($urandom_range(0, 7))};
            for (int c = 0; c < NUM_CH; c++) ch_data[c*32 +: 32] = $urandom;
            reg_data = $urandom;
            model_step();
            tick();
            check($sformatf("rand%0d", i), m_seg, m_cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
